// File: rtl/neuron_pkg.sv
// Shared types and helpers for the clocked leaky integrate-and-fire neuron.
// The neuron states, the membrane clamp and the width of the accumulator.
package neuron_pkg;

  typedef enum logic [1:0] {
    ST_INTEG,
    ST_FIRE_REQ,
    ST_FIRE_REL,
    ST_REFRACT
  } neuron_st_t;

  // Accumulator width: membrane + carry for N_IN weights + sign + leak headroom.
  function automatic int sum_bits(input int n_in, input int data_bits);
    return data_bits + ((n_in > 1) ? $clog2(n_in) : 0) + 2;
  endfunction

  function automatic int clamp_u(input int value, input int bits);
    int hi;
    hi = (1 << bits) - 1;
    if (value < 0) return 0;
    if (value > hi) return hi;
    return value;
  endfunction

endpackage

// File: rtl/neuron_lif_multi_if.sv
// Spike channels of one neuron: N_IN 4-phase inputs and one 4-phase output.
// 4-phase: sender raises req (data valid while req=1), receiver raises ack,
// sender drops req, receiver drops ack; a new transfer starts only after ack=0.
interface neuron_lif_multi_if #(
  parameter int N_IN = 4
);
  logic [N_IN-1:0] data_in;
  logic [N_IN-1:0] req_in;
  logic [N_IN-1:0] ack_in;
  logic            data_out;
  logic            req_out;
  logic            ack_out;

  modport master (
    output data_in, req_in, ack_out,
    input  ack_in, data_out, req_out
  );

  modport slave (
    input  data_in, req_in, ack_out,
    output ack_in, data_out, req_out
  );
endinterface

// File: rtl/neuron_in_chan.sv
// One 4-phase input receiver: detects a pending request, registers ack and
// flags a spike to the integrator when the request is taken with data=1.
module neuron_in_chan (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic data,
  input  logic accept_en,
  output logic ack,
  output logic spike_valid
);

  logic pending;

  assign pending     = req & ~ack;
  assign spike_valid = pending & accept_en & data;

  always_ff @(posedge clk) begin
    if (rst) begin
      ack <= 1'b0;
    end else if (pending && accept_en) begin
      ack <= 1'b1;
    end else if (!req) begin
      ack <= 1'b0;
    end
  end

endmodule

// File: rtl/neuron_lif_multi.sv
// Multi-input leaky integrate-and-fire neuron: weighted spike sum into a
// saturating membrane with periodic leak, 4-phase spike output, refractory.
module neuron_lif_multi
  import neuron_pkg::*;
#(
  parameter int N_IN                  = 4,
  parameter int DATA_BITS             = 8,
  parameter int thold                 = 64,
  parameter int weight_v [N_IN-1:0]   = '{default: 1},
  parameter int LEAK                  = 1,
  parameter int LEAK_PERIOD           = 8,
  parameter int REFRACT               = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  neuron_lif_multi_if.slave    bus,
  output logic [DATA_BITS-1:0] v_mem,
  output neuron_st_t           state
);

  localparam int SUM_W = sum_bits(N_IN, DATA_BITS);
  localparam int LC_W  = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;
  localparam int RC_W  = (REFRACT > 1) ? $clog2(REFRACT) : 1;

  neuron_st_t              state_d;
  logic                    accept_en;
  logic                    fire;
  logic                    leak_evt;
  logic                    out_q;
  logic [N_IN-1:0]         spike_valid;
  logic [N_IN-1:0]         ack_vec;
  logic [LC_W-1:0]         leak_cnt;
  logic [RC_W-1:0]         ref_cnt;
  logic signed [SUM_W-1:0] acc;
  logic [DATA_BITS-1:0]    v_next;

  for (genvar i = 0; i < N_IN; i++) begin : g_chan
    neuron_in_chan u_chan (
      .clk        (clk),
      .rst        (rst),
      .req        (bus.req_in[i]),
      .data       (bus.data_in[i]),
      .accept_en  (accept_en),
      .ack        (ack_vec[i]),
      .spike_valid(spike_valid[i])
    );
  end

  assign bus.ack_in   = ack_vec;
  assign bus.req_out  = out_q;
  assign bus.data_out = out_q;

  assign leak_evt = (leak_cnt == LC_W'(LEAK_PERIOD - 1));

  // Input and leak are merged at full width so a single clamp decides the result.
  always_comb begin
    acc = SUM_W'($signed({1'b0, v_mem}));
    for (int i = 0; i < N_IN; i++) begin
      if (spike_valid[i]) acc = acc + SUM_W'(weight_v[i]);
    end
    if (leak_evt) acc = acc - SUM_W'(LEAK);
    v_next = DATA_BITS'(clamp_u(int'(acc), DATA_BITS));
  end

  always_comb begin
    state_d   = state;
    accept_en = 1'b0;
    fire      = 1'b0;
    unique case (state)
      ST_INTEG: begin
        if (v_mem >= DATA_BITS'(thold)) begin
          fire    = 1'b1;
          state_d = ST_FIRE_REQ;
        end else begin
          accept_en = 1'b1;
        end
      end
      ST_FIRE_REQ: begin
        if (bus.ack_out) state_d = ST_FIRE_REL;
      end
      ST_FIRE_REL: begin
        if (!bus.ack_out) state_d = (REFRACT == 0) ? ST_INTEG : ST_REFRACT;
      end
      ST_REFRACT: begin
        accept_en = 1'b1;
        if (ref_cnt == '0) state_d = ST_INTEG;
      end
      default: state_d = ST_INTEG;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_INTEG;
      out_q    <= 1'b0;
      v_mem    <= '0;
      leak_cnt <= '0;
      ref_cnt  <= '0;
    end else begin
      state <= state_d;
      out_q <= (state_d == ST_FIRE_REQ);
      if (state == ST_INTEG) begin
        if (fire) begin
          v_mem    <= '0;
          leak_cnt <= '0;
        end else begin
          v_mem    <= v_next;
          leak_cnt <= leak_evt ? '0 : leak_cnt + 1'b1;
        end
      end
      // ref_cnt holds the remaining refractory cycles after the current one.
      if (state == ST_FIRE_REL && state_d == ST_REFRACT) begin
        ref_cnt <= RC_W'(REFRACT - 1);
      end else if (state == ST_REFRACT && ref_cnt != '0) begin
        ref_cnt <= ref_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_neuron_lif_multi.sv
// Bench for neuron_lif_multi: two configurations driven by directed handshakes,
// checked every cycle against an arithmetic model plus hand-computed values.
module tb_neuron_lif_multi;
  import neuron_pkg::*;

  localparam int W = 16;

  // Model view of the two instances: [0] = A, [1] = B.
  localparam int P_MAX    [2]    = '{255, 15};
  localparam int P_THOLD  [2]    = '{8, 15};
  localparam int P_LEAK   [2]    = '{0, 1};
  localparam int P_LP     [2]    = '{8, 4};
  localparam int P_REF    [2]    = '{2, 0};
  localparam int P_W      [2][4] = '{'{1, 2, 3, 4}, '{7, -5, 3, 2}};

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  neuron_lif_multi_if #(.N_IN(4)) bus_a ();
  neuron_lif_multi_if #(.N_IN(4)) bus_b ();

  logic [7:0] v_a;
  logic [3:0] v_b;
  neuron_st_t st_a;
  neuron_st_t st_b;

  neuron_lif_multi #(
    .N_IN(4), .DATA_BITS(8), .thold(8), .weight_v('{4, 3, 2, 1}),
    .LEAK(0), .LEAK_PERIOD(8), .REFRACT(2)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .v_mem(v_a), .state(st_a)
  );

  neuron_lif_multi #(
    .N_IN(4), .DATA_BITS(4), .thold(15), .weight_v('{2, 3, -5, 7}),
    .LEAK(1), .LEAK_PERIOD(4), .REFRACT(0)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .v_mem(v_b), .state(st_b)
  );

  int n_vec = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];

  // behavioural model
  int m_phase [2];
  int m_v     [2];
  int m_lc    [2];
  int m_rleft [2];
  bit m_ack   [2][4];

  function automatic neuron_st_t ph2st(input int p);
    case (p)
      1:       return ST_FIRE_REQ;
      2:       return ST_FIRE_REL;
      3:       return ST_REFRACT;
      default: return ST_INTEG;
    endcase
  endfunction

  task automatic model_step(input int k, input logic [3:0] rq, input logic [3:0] dt, input logic ao);
    int sum;
    int t;
    bit fire_now;
    bit take;
    bit leak_now;
    sum = 0;
    if (rst) begin
      m_phase[k] = 0; m_v[k] = 0; m_lc[k] = 0; m_rleft[k] = 0;
      for (int c = 0; c < 4; c++) m_ack[k][c] = 1'b0;
    end else begin
      fire_now = (m_phase[k] == 0) && (m_v[k] >= P_THOLD[k]);
      take     = (m_phase[k] == 0 && !fire_now) || (m_phase[k] == 3);
      for (int c = 0; c < 4; c++) begin
        if (rq[c] && !m_ack[k][c]) begin
          if (take) begin
            m_ack[k][c] = 1'b1;
            if (dt[c] && m_phase[k] == 0) sum += P_W[k][c];
          end
        end else if (m_ack[k][c] && !rq[c]) begin
          m_ack[k][c] = 1'b0;
        end
      end
      case (m_phase[k])
        0: begin
          if (fire_now) begin
            m_v[k] = 0; m_lc[k] = 0; m_phase[k] = 1;
          end else begin
            leak_now = (m_lc[k] == P_LP[k] - 1);
            m_lc[k]  = leak_now ? 0 : m_lc[k] + 1;
            t = m_v[k] + sum - (leak_now ? P_LEAK[k] : 0);
            if (t < 0) t = 0;
            if (t > P_MAX[k]) t = P_MAX[k];
            m_v[k] = t;
          end
        end
        1: if (ao) m_phase[k] = 2;
        2: if (!ao) begin
          m_phase[k] = (P_REF[k] == 0) ? 0 : 3;
          m_rleft[k] = P_REF[k];
        end
        default: begin
          m_rleft[k] = m_rleft[k] - 1;
          if (m_rleft[k] == 0) m_phase[k] = 0;
        end
      endcase
    end
  endtask

  function automatic logic [W-1:0] exp_word(input int k);
    logic [3:0] a;
    logic       r;
    for (int c = 0; c < 4; c++) a[c] = m_ack[k][c];
    r = (m_phase[k] == 1);
    return {ph2st(m_phase[k]), r, r, a, 8'(m_v[k])};
  endfunction

  function automatic logic [W-1:0] dut_word(input int k);
    if (k == 0) return {st_a, bus_a.req_out, bus_a.data_out, bus_a.ack_in, v_a};
    return {st_b, bus_b.req_out, bus_b.data_out, bus_b.ack_in, 4'b0, v_b};
  endfunction

  always @(posedge clk) begin
    model_step(0, bus_a.req_in, bus_a.data_in, bus_a.ack_out);
    model_step(1, bus_b.req_in, bus_b.data_in, bus_b.ack_out);
    exp_q.push_back(exp_word(0));
    exp_q.push_back(exp_word(1));
  end

  // scoreboard: one compare per instance per cycle
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [W-1:0] g;
    for (int k = 0; k < 2; k++) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = dut_word(k);
        n_vec++;
        if (g !== e) begin
          n_bad++;
          $display("FAIL cycle_dut%0d t=%0t got=%h exp=%h (st,req,data,ack,v)", k, $time, g, e);
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int k, input int ch, input logic r, input logic d);
    if (k == 0) begin
      bus_a.req_in[ch] = r; bus_a.data_in[ch] = d;
    end else begin
      bus_b.req_in[ch] = r; bus_b.data_in[ch] = d;
    end
  endtask

  task automatic set_ack_out(input int k, input logic a);
    if (k == 0) bus_a.ack_out = a;
    else        bus_b.ack_out = a;
  endtask

  function automatic logic get_ack(input int k, input int ch);
    return (k == 0) ? bus_a.ack_in[ch] : bus_b.ack_in[ch];
  endfunction

  function automatic logic get_req_out(input int k);
    return (k == 0) ? bus_a.req_out : bus_b.req_out;
  endfunction

  function automatic int get_v(input int k);
    return (k == 0) ? int'(v_a) : int'(v_b);
  endfunction

  task automatic send(input int k, input int ch, input logic d, output int v_seen);
    int n;
    set_in(k, ch, 1'b1, d);
    n = 0;
    do begin tick(1); n++; end while (!get_ack(k, ch) && n < 20);
    check($sformatf("ack_rise_dut%0d_ch%0d", k, ch), int'(get_ack(k, ch)), 1);
    v_seen = get_v(k);
    set_in(k, ch, 1'b0, 1'b0);
    n = 0;
    do begin tick(1); n++; end while (get_ack(k, ch) && n < 20);
    check($sformatf("ack_fall_dut%0d_ch%0d", k, ch), int'(get_ack(k, ch)), 0);
  endtask

  task automatic out_hs(input int k, input int hold);
    int n;
    n = 0;
    while (!get_req_out(k) && n < 20) begin tick(1); n++; end
    check($sformatf("req_out_rise_dut%0d", k), int'(get_req_out(k)), 1);
    tick(hold);
    set_ack_out(k, 1'b1);
    n = 0;
    do begin tick(1); n++; end while (get_req_out(k) && n < 20);
    check($sformatf("req_out_fall_dut%0d", k), int'(get_req_out(k)), 0);
    set_ack_out(k, 1'b0);
    tick(1);
  endtask

  initial begin
    int vs;
    bus_a.req_in = '0; bus_a.data_in = '0; bus_a.ack_out = 1'b0;
    bus_b.req_in = '0; bus_b.data_in = '0; bus_b.ack_out = 1'b0;
    rst = 1'b1;
    tick(2);
    check("rst_v_a", int'(v_a), 0);
    check("rst_req_out_a", int'(bus_a.req_out), 0);
    check("rst_state_a", int'(st_a), int'(ST_INTEG));
    rst = 1'b0;

    // data=0 still handshakes but adds nothing
    send(0, 2, 1'b0, vs);
    check("zero_data_v", vs, 0);

    // reset in the middle of an input handshake
    set_in(0, 3, 1'b1, 1'b1);
    tick(1);
    check("pre_rst_v", int'(v_a), 4);
    rst = 1'b1;
    tick(2);
    check("mid_rst_ack", int'(bus_a.ack_in), 0);
    check("mid_rst_v", int'(v_a), 0);
    check("mid_rst_state", int'(st_a), int'(ST_INTEG));
    set_in(0, 3, 1'b0, 1'b0);
    rst = 1'b0;
    tick(1);

    // two spikes on channel 3 (weight 4) reach threshold 8
    send(0, 3, 1'b1, vs);
    check("single_v1", vs, 4);
    send(0, 3, 1'b1, vs);
    check("single_v2", vs, 8);
    check("single_fire_req", int'(bus_a.req_out), 1);
    check("single_fire_v", int'(v_a), 0);
    out_hs(0, 0);
    tick(3);

    // all four channels at once: 1+2+3+4
    for (int c = 0; c < 4; c++) set_in(0, c, 1'b1, 1'b1);
    tick(1);
    check("simul_ack", int'(bus_a.ack_in), 15);
    check("simul_v", int'(v_a), 10);
    for (int c = 0; c < 4; c++) set_in(0, c, 1'b0, 1'b0);
    tick(1);
    check("simul_fire", int'(bus_a.req_out), 1);
    out_hs(0, 0);
    tick(3);

    // backpressure while the output waits, then refractory discard
    send(0, 3, 1'b1, vs);
    send(0, 3, 1'b1, vs);
    set_in(0, 0, 1'b1, 1'b1);
    tick(10);
    check("bp_ack", int'(bus_a.ack_in[0]), 0);
    check("bp_state", int'(st_a), int'(ST_FIRE_REQ));
    set_ack_out(0, 1'b1);
    tick(1);
    check("bp_req_drop", int'(bus_a.req_out), 0);
    set_ack_out(0, 1'b0);
    tick(2);
    check("refr_ack", int'(bus_a.ack_in[0]), 1);
    check("refr_state", int'(st_a), int'(ST_REFRACT));
    set_in(0, 0, 1'b0, 1'b0);
    tick(3);
    check("refr_v", int'(v_a), 0);
    check("refr_back_integ", int'(st_a), int'(ST_INTEG));

    // negative weight clamps at zero
    send(1, 2, 1'b1, vs);
    send(1, 1, 1'b1, vs);
    check("clamp_zero", vs, 0);

    // leak from about 5 down to the floor
    set_in(1, 2, 1'b1, 1'b1);
    set_in(1, 3, 1'b1, 1'b1);
    tick(1);
    set_in(1, 2, 1'b0, 1'b0);
    set_in(1, 3, 1'b0, 1'b0);
    tick(30);
    check("leak_floor", int'(v_b), 0);

    // saturation at 15 on a 4-bit membrane, then fire
    send(1, 0, 1'b1, vs);
    send(1, 0, 1'b1, vs);
    send(1, 0, 1'b1, vs);
    check("sat_v", vs, 15);
    check("sat_fire", int'(bus_b.req_out), 1);
    out_hs(1, 0);
    check("sat_back_integ", int'(st_b), int'(ST_INTEG));

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/neuron_lif_multi.md
# neuron_lif_multi

Synchronous, multi-input leaky integrate-and-fire neuron: the clocked successor of the single-input asynchronous neuron. It accepts spikes on `N_IN` independent 4-phase req/ack channels and applies a per-channel signed weight. It integrates into a saturating membrane register with periodic leak, and emits one spike on a 4-phase output channel when the threshold is reached, followed by a refractory period. It sits between layers of the network in the clocked fabric and chains output-to-input with other instances.

## Interface
Parameters:
- `N_IN`, 4: number of input channels (1..16)
- `DATA_BITS`, 8: membrane width, unsigned
- `thold`, 64: firing threshold, 1..2^DATA_BITS-1
- `weight_v [N_IN-1:0]`, all 1: signed per-channel weight, range -(2^(DATA_BITS-1))..2^(DATA_BITS-1)-1
- `LEAK`, 1: amount subtracted per leak event (0 disables leak)
- `LEAK_PERIOD`, 8: cycles between leak events, ≥1
- `REFRACT`, 2: refractory cycles after a spike, ≥0

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `data_in` in N_IN: spike bit per channel, valid while `req_in[i]`=1
- `req_in` in N_IN: request per channel
- `ack_in` out N_IN: acknowledge per channel
- `data_out` out 1: spike bit, 1 while `req_out`=1
- `req_out` out 1: request to next neuron
- `ack_out` in 1: acknowledge from next neuron
- `v_mem` out DATA_BITS: membrane value, debug/observation

## Operation
- States: INTEG, FIRE_REQ, FIRE_REL, REFRACT. Reset sets state to INTEG. All outputs are 0 after reset, `v_mem`=0, and the leak counter is 0.
- Input channel i is pending when `req_in[i]`=1 and `ack_in[i]`=0.
- In INTEG, all pending channels are accepted in the same cycle. Their contribution is sum of `weight_v[i]` over accepted i with `data_in[i]`=1. An accepted channel with `data_in`=0 contributes 0 but is still acknowledged.
- `ack_in[i]` rises the cycle after acceptance. It stays high until `req_in[i]` is sampled low, then falls the next cycle (4-phase). A channel cannot be re-accepted while its `ack_in` is high.
- In INTEG, the leak counter increments every cycle and wraps at LEAK_PERIOD-1. On the wrap cycle a leak event applies `-LEAK`.
- Membrane update: `v_next = clamp(v + sum - leak_term, 0, 2^DATA_BITS-1)`, computed at width DATA_BITS+clog2(N_IN)+2 signed. Input and leak in the same cycle are combined before clamping.
- In INTEG, when the registered `v_mem` ≥ `thold`, the neuron goes to FIRE_REQ on the next cycle. On entry to FIRE_REQ it sets `v_mem`=0 and leak counter=0. No inputs are accepted that cycle.
- FIRE_REQ:
  - Outputs: `req_out`=1, `data_out`=1.
  - Exit: on `ack_out`=1, go to FIRE_REL and drop `req_out`/`data_out`.
- FIRE_REL: wait for `ack_out`=0.
  - If REFRACT=0, go to INTEG.
  - Otherwise go to REFRACT.
- REFRACT: lasts exactly REFRACT cycles, then returns to INTEG.
  - Pending inputs are accepted and acknowledged but discarded; spikes are lost.
  - No leak events occur.
- FIRE_REQ/FIRE_REL: pending inputs are not accepted (backpressure). Handshakes already in progress complete their release phase normally.
- `rst` mid-handshake: all acks and `req_out` drop the following cycle and in-flight spikes are discarded.

## Timing
- Input acceptance to `v_mem` update: 1 cycle.
- `v_mem` ≥ `thold` to `req_out` high: 1 cycle. Minimum spike-in to `req_out` latency is therefore 2 cycles.
- `ack_out` high to `req_out` low: 1 cycle.
- `ack_out` low to INTEG: 1 cycle if REFRACT=0, else REFRACT+1 cycles.
- `req_in` to `ack_in`: 1 cycle when in INTEG or REFRACT.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Package `neuron_pkg`: state enum `neuron_st_t`, function `clamp_u(value, bits)`, and width helper `sum_bits(N_IN, DATA_BITS)`.
- Sub-module `neuron_in_chan`: one per channel, instantiated N_IN times. It holds the 4-phase receiver (pending detection, `ack_in` register) and exposes `accept_en` in and `spike_valid` out.
- The top level holds the FSM, adder tree, leak counter, and membrane register.

## Test plan
- Reset: assert `rst` for 2 cycles mid-handshake -> all outputs 0, `v_mem`=0, state INTEG.
- Single-channel integration: N_IN=4, weights {1,2,3,4}, thold=8, LEAK=0. Send two spikes on channel 3 -> `v_mem` becomes 4 then 8, `req_out` high 1 cycle later, `v_mem`=0.
- Simultaneous inputs: all four channels pending in one cycle with `data_in`=1 -> all acked next cycle, `v_mem` += 10. Then apply weight -5 on a channel with `v_mem`=3 -> clamp to 0.
- Leak: `v_mem`=5, LEAK=1, LEAK_PERIOD=4, no inputs -> `v_mem` decrements every 4 cycles down to 0 and stays at 0.
- Backpressure/refractory: hold `ack_out` low 10 cycles while a spike arrives -> `ack_in` stays 0. Complete the output handshake -> in REFRACT=2 the spike is acked and `v_mem` stays 0.
- Saturation: DATA_BITS=4, thold=15, weight 7, three spikes -> `v_mem` 7, 14, then 15 (clamped), fire.
